cpu_control: RTL

Instruction register, decoder and control FSM for the Simple RISC Machine. It sits directly upstream of `datapath` and drives every one of its control inputs. It sequences the MOV-immediate, MOV-register, ADD, CMP, AND and MVN instructions through the register file, the A/B/C pipeline registers and the status register. A `start`/`wait` handshake exposes it to the test harness or to a later fetch stage.

---
 rtl/cpu_control.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cpu_control.sv
// Instruction register, decoder and Moore control FSM for the Simple RISC Machine datapath.
// Optional MVN support is enabled with `define CPU_CTRL_MVN_EN; otherwise 101/11 is treated as illegal.
module cpu_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [1:0]  vsel,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_t;

  typedef struct packed {
    logic       w;
    logic [1:0] vsel;
    logic [2:0] writenum;
    logic [2:0] readnum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
  } ctl_t;

  state_t      state, state_nxt;
  logic [15:0] ir;
  ctl_t        ctl;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic       is_movi, is_movr, is_mvn, is_alu3, is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
`ifdef CPU_CTRL_MVN_EN
  assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
`else
  assign is_mvn  = 1'b0;
`endif
  // ADD, CMP and AND all read both Rn and Rm
  assign is_alu3 = (opcode == 3'b101) && (op != 2'b11);
  assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);

  // IR only captures in WAIT so an in-flight instruction is never disturbed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (load && state == S_WAIT) ir <= in;
    end
  end

  always_comb begin
    state_nxt = state;
    ctl       = '0;
    unique case (state)
      S_WAIT: begin
        ctl.w = 1'b1;
        if (s) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi)                state_nxt = S_WRITE_IMM;
        else if (is_movr || is_mvn) state_nxt = S_GET_B;
        else if (is_alu3)           state_nxt = S_GET_A;
        else                        state_nxt = S_WAIT;
      end
      S_WRITE_IMM: begin
        ctl.writenum = rn;
        ctl.vsel     = 2'b10;
        ctl.write    = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_GET_A: begin
        ctl.readnum = rn;
        ctl.loada   = 1'b1;
        state_nxt   = S_GET_B;
      end
      S_GET_B: begin
        ctl.readnum = rm;
        ctl.loadb   = 1'b1;
        state_nxt   = S_ALU;
      end
      S_ALU: begin
        // single-operand ops see 0 on the A side
        ctl.asel  = is_movr || is_mvn;
        ctl.loadc = !is_cmp;
        ctl.loads = is_cmp;
        state_nxt = is_cmp ? S_WAIT : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        ctl.writenum = rd;
        ctl.vsel     = 2'b00;
        ctl.write    = 1'b1;
        state_nxt    = S_WAIT;
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  assign w        = ctl.w;
  assign vsel     = ctl.vsel;
  assign writenum = ctl.writenum;
  assign readnum  = ctl.readnum;
  assign write    = ctl.write;
  assign loada    = ctl.loada;
  assign loadb    = ctl.loadb;
  assign loadc    = ctl.loadc;
  assign loads    = ctl.loads;
  assign asel     = ctl.asel;
  assign bsel     = 1'b0;
  assign shift    = ir[4:3];
  assign ALUop    = ir[12:11];
  assign sximm5   = {{11{ir[4]}}, ir[4:0]};
  assign sximm8   = {{8{ir[7]}}, ir[7:0]};

endmodule
